// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks: Gray/binary conversion
// and depth/pointer-width derivation from the RAM address width.
package fifo_pkg;

    localparam int unsigned MAX_ADDR_SIZE = 16;
    localparam int unsigned MAX_PTR_W     = MAX_ADDR_SIZE + 1;

    function automatic int unsigned fifo_depth(input int unsigned addr_size);
        return 32'(1) << addr_size;
    endfunction

    function automatic int unsigned fifo_ptr_w(input int unsigned addr_size);
        return addr_size + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // XOR prefix from the MSB down; zero extension leaves the result unchanged.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = int'(MAX_PTR_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_level_ctrl_gray2bin.sv
// Purely combinational Gray-to-binary converter, shared by the write- and
// read-side pointer controllers.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    assign o_bin = W'(gray2bin(MAX_PTR_W'(i_gray)));

endmodule

// File: rtl/wptr_level_ctrl.sv
// Write-domain pointer/status controller: binary and Gray write pointers,
// fill level against the synchronised read pointer, full/almost-full/overflow.
module wptr_level_ctrl
    import fifo_pkg::*;
#(
    parameter  int unsigned ADDR_SIZE = 3,
    localparam int unsigned PTR_W     = fifo_ptr_w(ADDR_SIZE)
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [PTR_W-1:0]     wq2_rptr,
    input  logic [PTR_W-1:0]     wafull_thresh,
    input  logic                 wovf_clr,
    output logic                 wpush,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [PTR_W-1:0]     wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [PTR_W-1:0]     wlevel,
    output logic                 woverflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);

    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_wlevel;
    logic             r_wfull;
    logic             r_walmost_full;
    logic             r_woverflow;

    logic [PTR_W-1:0] w_rbin_s;
    logic [PTR_W-1:0] w_wbin_next;
    logic [PTR_W-1:0] w_wgray_next;
    logic [PTR_W-1:0] w_wlevel_next;
    logic             w_wpush;
    logic             w_wfull_val;
    logic             w_walmost_val;
    logic             w_ovf_next;

    gray2bin_conv #(
        .W (PTR_W)
    ) u_rptr_g2b (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin_s)
    );

    // Next-state: pointer advance, level from both new pointers, flag values.
    always_comb begin
        w_wpush       = winc & ~r_wfull;
        w_wbin_next   = r_wbin + PTR_W'(w_wpush);
        w_wgray_next  = PTR_W'(bin2gray(MAX_PTR_W'(w_wbin_next)));
        w_wlevel_next = w_wbin_next - w_rbin_s;
        w_wfull_val   = (w_wlevel_next == PTR_W'(DEPTH));
        w_walmost_val = (w_wlevel_next >= wafull_thresh);
        w_ovf_next    = (winc & r_wfull) | (r_woverflow & ~wovf_clr);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wlevel       <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wlevel       <= w_wlevel_next;
            r_wfull        <= w_wfull_val;
            r_walmost_full <= w_walmost_val;
            r_woverflow    <= w_ovf_next;
        end
    end

    assign wpush        = w_wpush;
    assign waddr        = r_wbin[ADDR_SIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_level_ctrl.sv
// Self-checking bench for wptr_level_ctrl (ADDR_SIZE=3): integer occupancy model
// compared every cycle, directed scenarios with literal expectations, random phase.
module tb_wptr_level_ctrl;

    localparam int AS    = 3;
    localparam int PW    = 4;
    localparam int DEPTH = 8;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          winc;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] wafull_thresh;
    logic          wovf_clr;
    logic          wpush;
    logic [AS-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic          walmost_full;
    logic [PW-1:0] wlevel;
    logic          woverflow;

    wptr_level_ctrl #(.ADDR_SIZE(AS)) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .winc          (winc),
        .wq2_rptr      (wq2_rptr),
        .wafull_thresh (wafull_thresh),
        .wovf_clr      (wovf_clr),
        .wpush         (wpush),
        .waddr         (waddr),
        .wptr          (wptr),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel),
        .woverflow     (woverflow)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: total accepted writes and reads as plain integers.
    int m_w, m_r, m_level;
    bit m_full, m_afull, m_ovf;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic set_rd(input int rc);
        chk("rptr_legal", (rc <= m_w && m_w - rc <= DEPTH), 1);
        m_r      = rc;
        wq2_rptr = gray4(rc);
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        winc = 1'b0; wovf_clr = 1'b0;
        m_w = 0; m_r = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
        wq2_rptr = '0;
        @(posedge wclk); #1;
        wrst = 1'b0;
    endtask

    // One clock edge, then advance the model with the inputs that edge saw.
    task automatic step();
        bit push, set;
        @(posedge wclk); #1;
        if (!wrst) begin
            push    = winc && !m_full;
            set     = winc && m_full;
            m_w     = m_w + int'(push);
            m_level = m_w - m_r;
            m_full  = (m_level == DEPTH);
            m_afull = (m_level >= int'(wafull_thresh));
            m_ovf   = set || (m_ovf && !wovf_clr);
        end
    endtask

    bit chk_en = 1'b0;

    always @(negedge wclk) begin
        if (chk_en) begin
            chk("wpush",        wpush,        longint'(winc && !m_full));
            chk("waddr",        waddr,        m_w % DEPTH);
            chk("wptr",         wptr,         gray4(m_w));
            chk("wfull",        wfull,        m_full);
            chk("walmost_full", walmost_full, m_afull);
            chk("wlevel",       wlevel,       m_level);
            chk("woverflow",    woverflow,    m_ovf);
        end
    end

    initial begin
        int wraps, msb_tog, full_seen, af_seen;
        logic [AS-1:0] prev_addr;
        logic          prev_msb;

        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0;
        wq2_rptr = '0; wafull_thresh = 4'd6;
        m_w = 0; m_r = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        #2;
        chk("rst_wptr", wptr, 0);
        chk("rst_wfull", wfull, 0);
        chk_en = 1'b1;
        do_reset();

        // Mid-stream asynchronous reset with wptr = 0110.
        winc = 1'b1;
        repeat (4) step();
        chk("pre_rst_wptr", wptr, 4'b0110);
        #2 wrst = 1'b1;
        #1;
        chk("arst_wptr", wptr, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_wlevel", wlevel, 0);
        chk("arst_wfull", wfull, 0);
        chk("arst_wovf", woverflow, 0);
        do_reset();

        // Fill to full, then one blocked write.
        wafull_thresh = 4'd6;
        winc = 1'b1;
        repeat (5) step();
        chk("fill_af_5", walmost_full, 0);
        step();
        chk("fill_af_6", walmost_full, 1);
        step(); step();
        chk("fill_full_8", wfull, 1);
        chk("fill_level_8", wlevel, 8);
        chk("fill_wptr_8", wptr, 4'b1100);
        chk("fill_wpush_9", wpush, 0);
        step();
        chk("ovf_wptr_hold", wptr, 4'b1100);
        chk("ovf_set", woverflow, 1);

        // Overflow set beats simultaneous clear; plain clear then drops it.
        wovf_clr = 1'b1;
        step();
        chk("ovf_race_keep", woverflow, 1);
        winc = 1'b0;
        step();
        chk("ovf_cleared", woverflow, 0);
        wovf_clr = 1'b0;

        // Drain while full: read pointer shows 3 words consumed.
        set_rd(3);
        step();
        chk("drain_full", wfull, 0);
        chk("drain_level", wlevel, 5);
        chk("drain_af", walmost_full, 0);
        winc = 1'b1;
        repeat (3) step();
        chk("refill_full", wfull, 1);
        winc = 1'b0;

        // Wrap with reads trailing two behind.
        do_reset();
        winc = 1'b1;
        repeat (2) step();
        wraps = 0; msb_tog = 0; full_seen = 0;
        prev_addr = waddr; prev_msb = wptr[3];
        for (int i = 0; i < 20; i++) begin
            set_rd(m_w - 2);
            step();
            if (prev_addr == 3'd7 && waddr == 3'd0) wraps++;
            if (wptr[3] != prev_msb) msb_tog++;
            if (wfull) full_seen++;
            chk("wrap_level", (wlevel == 4'd2 || wlevel == 4'd3), 1);
            prev_addr = waddr; prev_msb = wptr[3];
        end
        winc = 1'b0;
        chk("wrap_count", wraps, 2);
        chk("wrap_msb_toggles", msb_tog, 2);
        chk("wrap_no_full", full_seen, 0);

        // Threshold 0: flag from the first edge after reset.
        wafull_thresh = 4'd0;
        do_reset();
        step();
        chk("thresh0_af", walmost_full, 1);

        // Threshold above depth: never asserts through a full fill.
        wafull_thresh = 4'd9;
        do_reset();
        winc = 1'b1; af_seen = 0;
        repeat (9) begin
            step();
            if (walmost_full) af_seen++;
        end
        chk("thresh9_full", wfull, 1);
        chk("thresh9_af_never", af_seen, 0);
        winc = 1'b0;

        // Random traffic against the model.
        wafull_thresh = 4'(6);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            winc     = ($urandom_range(0, 9) < 6);
            wovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0 && m_r < m_w)
                set_rd(m_r + 1 + int'($urandom_range(0, m_w - m_r - 1)));
            if ($urandom_range(0, 49) == 0)
                wafull_thresh = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
